cp0_ctrl: RTL and testbench

Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline, sitting at the M stage. It consumes the exception code, PC and branch-delay flag that the pipeline registers carry down from D/E, and the external hardware interrupt lines. It decides whether to take an exception or interrupt and drives the `req` flush signal back into every pipeline register, including D/E. It also holds SR, Cause, EPC and PRId for `mfc0`/`mtc0`/`eret`.

---
 rtl/cp0_ctrl.sv | 93 +++++++++
 tb/tb_cp0_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_ctrl.sv
// CP0 exception/interrupt controller at M: SR, Cause, EPC, PRId plus the flush request.
// req and DOut are combinational; register updates are visible one cycle after the edge; no backpressure.
package cp0_pkg;
   localparam logic [31:0] PRID      = 32'h2022_0007;
   localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
endpackage

module cp0_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        we,
   input  logic        EXLClr,
   input  logic [31:0] PC_M,
   input  logic        BD_M,
   input  logic [4:0]  ExcCode_M,
   input  logic [5:0]  HWInt,
   output logic [31:0] DOut,
   output logic [31:0] EPCOut,
   output logic        req
);
   import cp0_pkg::*;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   assign int_req = sr_ie & ~sr_exl & (|(HWInt & sr_im));
   assign exc_req = (ExcCode_M != 5'd0) & ~sr_exl;
   assign req     = int_req | exc_req;

   assign sr_word    = {16'h0000, sr_im, 8'h00, sr_exl, sr_ie};
   assign cause_word = {cause_bd, 15'h0000, cause_ip, 3'b000, cause_exc, 2'b00};
   assign EPCOut     = epc;

   always_comb begin
      DOut = 32'h0000_0000;
      case (A1)
         REG_SR:    DOut = sr_word;
         REG_CAUSE: DOut = cause_word;
         REG_EPC:   DOut = epc;
         REG_PRID:  DOut = PRID;
         default:   DOut = 32'h0000_0000;
      endcase
   end

   // A flushed mtc0/eret must not commit, hence req ahead of EXLClr and we.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im     <= 6'd0;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= 6'd0;
         cause_exc <= 5'd0;
         epc       <= 32'h0000_0000;
      end else begin
         cause_ip <= HWInt;
         if (req) begin
            sr_exl    <= 1'b1;
            cause_bd  <= BD_M;
            cause_exc <= int_req ? 5'd0 : ExcCode_M;
            epc       <= BD_M ? (PC_M - 32'd4) : PC_M;
         end else if (EXLClr) begin
            sr_exl <= 1'b0;
         end else if (we) begin
            if (A2 == REG_SR) begin
               sr_im  <= DIn[15:10];
               sr_exl <= DIn[1];
               sr_ie  <= DIn[0];
            end else if (A2 == REG_EPC) begin
               epc <= DIn;
            end
         end
      end
   end
endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: expectations queued with each stimulus step, drained at sample time.
module tb_cp0_ctrl;
   import cp0_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  A1, A2;
   logic [31:0] DIn;
   logic        we, EXLClr;
   logic [31:0] PC_M;
   logic        BD_M;
   logic [4:0]  ExcCode_M;
   logic [5:0]  HWInt;
   logic [31:0] DOut, EPCOut;
   logic        req;

   int total = 0;
   int bad   = 0;

   localparam int SEL_DOUT = 0;
   localparam int SEL_REQ  = 1;
   localparam int SEL_EPC  = 2;

   typedef struct {
      string       tag;
      int          sel;
      logic [4:0]  addr;
      logic [31:0] exp;
   } exp_t;

   exp_t sbq[$];

   cp0_ctrl dut (
      .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .we(we),
      .EXLClr(EXLClr), .PC_M(PC_M), .BD_M(BD_M), .ExcCode_M(ExcCode_M),
      .HWInt(HWInt), .DOut(DOut), .EPCOut(EPCOut), .req(req)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input int sel, input logic [4:0] addr, input logic [31:0] exp);
      exp_t e;
      e.tag = tag; e.sel = sel; e.addr = addr; e.exp = exp;
      sbq.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      logic [31:0] got;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         if (e.sel == SEL_DOUT) A1 = e.addr;
         #1;
         case (e.sel)
            SEL_DOUT: got = DOut;
            SEL_REQ:  got = {31'd0, req};
            default:  got = EPCOut;
         endcase
         chk(e.tag, got, e.exp);
      end
   endtask

   initial begin
      reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; we = 1'b0; EXLClr = 1'b0;
      PC_M = 32'd0; BD_M = 1'b0; ExcCode_M = 5'd0; HWInt = 6'd0;
      repeat (2) @(posedge clk);

      // reset state
      @(negedge clk); reset = 1'b0;
      push("rst_sr", SEL_DOUT, 5'd12, 32'h0);
      push("rst_cause", SEL_DOUT, 5'd13, 32'h0);
      push("rst_epc", SEL_DOUT, 5'd14, 32'h0);
      push("rst_prid", SEL_DOUT, 5'd15, PRID);
      push("rst_unmapped", SEL_DOUT, 5'd3, 32'h0);
      push("rst_req", SEL_REQ, 5'd0, 32'h0);
      push("rst_epcout", SEL_EPC, 5'd0, 32'h0);
      drain();

      // mtc0 SR, then EPC, then Cause and PRId (ignored)
      @(negedge clk); we = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
      push("mtc0_sr_noreq", SEL_REQ, 5'd0, 32'h0);
      drain();
      @(negedge clk); A2 = 5'd14; DIn = 32'h0000_3010;
      push("mtc0_sr", SEL_DOUT, 5'd12, 32'h0000_FC01);
      drain();
      @(negedge clk); A2 = 5'd13; DIn = 32'hFFFF_FFFF;
      push("mtc0_epc", SEL_EPC, 5'd0, 32'h0000_3010);
      drain();
      @(negedge clk); A2 = 5'd15;
      push("mtc0_cause_ign", SEL_DOUT, 5'd13, 32'h0);
      drain();
      @(negedge clk); we = 1'b0;
      push("mtc0_prid_ign", SEL_DOUT, 5'd15, PRID);
      drain();

      // exception in a delay slot
      @(negedge clk); ExcCode_M = 5'd10; PC_M = 32'h0000_3008; BD_M = 1'b1;
      push("exc_req", SEL_REQ, 5'd0, 32'h1);
      drain();
      @(negedge clk);
      push("exc_epc", SEL_EPC, 5'd0, 32'h0000_3004);
      push("exc_cause", SEL_DOUT, 5'd13, 32'h8000_0028);
      push("exc_sr", SEL_DOUT, 5'd12, 32'h0000_FC03);
      push("exc_nested", SEL_REQ, 5'd0, 32'h0);
      drain();

      // eret, then program SR for interrupt 0 only
      @(negedge clk); EXLClr = 1'b1; ExcCode_M = 5'd0; BD_M = 1'b0;
      push("eret_noreq", SEL_REQ, 5'd0, 32'h0);
      drain();
      @(negedge clk); EXLClr = 1'b0; we = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
      push("eret_sr", SEL_DOUT, 5'd12, 32'h0000_FC01);
      drain();

      // interrupt beats a simultaneous exception
      @(negedge clk); we = 1'b0; HWInt = 6'b000001; ExcCode_M = 5'd4; PC_M = 32'h0000_3020;
      push("int_sr", SEL_DOUT, 5'd12, 32'h0000_0401);
      push("int_req", SEL_REQ, 5'd0, 32'h1);
      drain();
      @(negedge clk); ExcCode_M = 5'd0;
      push("int_cause", SEL_DOUT, 5'd13, 32'h0000_0400);
      push("int_epc", SEL_EPC, 5'd0, 32'h0000_3020);
      push("int_held", SEL_REQ, 5'd0, 32'h0);
      drain();

      // eret with the line still high: taken again right after EXL clears
      @(negedge clk); EXLClr = 1'b1;
      push("int_eret_noreq", SEL_REQ, 5'd0, 32'h0);
      drain();
      @(negedge clk); EXLClr = 1'b0; PC_M = EXC_ENTRY + 32'd8;
      push("int_retake", SEL_REQ, 5'd0, 32'h1);
      drain();
      @(negedge clk);
      push("int_retake_epc", SEL_EPC, 5'd0, EXC_ENTRY + 32'd8);
      push("int_retake_held", SEL_REQ, 5'd0, 32'h0);
      drain();

      // req suppresses a same-cycle mtc0 EPC
      @(negedge clk); EXLClr = 1'b1; HWInt = 6'd0;
      drain();
      @(negedge clk); EXLClr = 1'b0; we = 1'b1; A2 = 5'd14; DIn = 32'h1234_5678;
      ExcCode_M = 5'd12; PC_M = 32'h0000_3100;
      push("sup_req", SEL_REQ, 5'd0, 32'h1);
      drain();
      @(negedge clk); we = 1'b0;
      push("sup_epc", SEL_EPC, 5'd0, 32'h0000_3100);
      push("sup_cause", SEL_DOUT, 5'd13, 32'h0000_0030);
      drain();

      // reset mid-handler wins over a pending mtc0
      @(negedge clk); reset = 1'b1; we = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEF;
      drain();
      @(negedge clk); reset = 1'b0; we = 1'b0; ExcCode_M = 5'd0;
      push("rst2_sr", SEL_DOUT, 5'd12, 32'h0);
      push("rst2_cause", SEL_DOUT, 5'd13, 32'h0);
      push("rst2_epc", SEL_EPC, 5'd0, 32'h0);
      push("rst2_req", SEL_REQ, 5'd0, 32'h0);
      drain();

      // interrupt masked by IE=0 after reset; EPC wrap in a delay slot at PC 0
      @(negedge clk); HWInt = 6'b111111;
      push("ie_off_noreq", SEL_REQ, 5'd0, 32'h0);
      drain();
      @(negedge clk); HWInt = 6'd0; ExcCode_M = 5'd1; BD_M = 1'b1; PC_M = 32'h0000_0000;
      push("wrap_req", SEL_REQ, 5'd0, 32'h1);
      drain();
      @(negedge clk); ExcCode_M = 5'd0; BD_M = 1'b0;
      push("wrap_epc", SEL_EPC, 5'd0, 32'hFFFF_FFFC);
      push("wrap_cause", SEL_DOUT, 5'd13, 32'h8000_0004);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
